// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, taken-branch
// squashes and HALT draining, with optional statistics counters.
// Optional feature macro: HAZARD_STATS_EN (stall/flush counters built when defined).
module hazard_controller #(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 idValid,
  input  logic [4:0]           idRs,
  input  logic [4:0]           idRt,
  input  logic                 idUsesRt,
  input  logic                 idHalt,
  input  logic                 exMemRead,
  input  logic [4:0]           exRt,
  input  logic                 branchTaken,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 ifIdFlush,
  output logic                 idExFlush,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stallCount,
  output logic [CNT_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             cur_state, nxt_state;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               load_use;
  logic               halt_accept;

  // Load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = idValid & exMemRead & (exRt != 5'd0) &
               ((exRt == idRs) | (idUsesRt & (exRt == idRt)));
  end

  // HALT is accepted only when neither a branch squash nor a stall wins.
  always_comb begin
    halt_accept = (cur_state == RUN) & ~branchTaken & ~load_use & idHalt & idValid;
  end

  // Pipeline control outputs; reset forces everything quiet in the same cycle.
  always_comb begin
    pcWrite   = 1'b0;
    ifIdWrite = 1'b0;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      case (cur_state)
        RUN: begin
          pcWrite   = 1'b1;
          ifIdWrite = 1'b1;
          if (branchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
          end else if (load_use) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
          end else if (idHalt && idValid) begin
            pcWrite   = 1'b0;
            ifIdFlush = 1'b1;
          end
        end
        DRAIN: begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
        end
        HALTED:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and drain counter.
  always_comb begin
    nxt_state = cur_state;
    drain_nxt = drain_cnt;
    case (cur_state)
      IDLE: if (start) nxt_state = RUN;
      RUN: begin
        if (halt_accept) begin
          nxt_state = DRAIN;
          drain_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) nxt_state = HALTED;
        else                 drain_nxt = drain_cnt - DRAIN_W'(1);
      end
      default: ;
    endcase
  end

  // State and drain counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      drain_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      drain_cnt <= drain_nxt;
    end
  end

  assign state = cur_state;

`ifdef HAZARD_STATS_EN
  logic                 stall_cycle;
  logic                 flush_cycle;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Qualify statistics events: branch squash outranks a load-use stall.
  always_comb begin
    stall_cycle = (cur_state == RUN) & load_use & ~branchTaken;
    flush_cycle = (cur_state == RUN) & branchTaken;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_cycle && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (flush_cycle && (flush_q != '1)) flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stallCount = stall_q;
  assign flushCount = flush_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vectors, a cycle model
// of the control rules, and literal checks on key scenarios.
module tb_hazard_controller;

  localparam int unsigned CW = 4;
  localparam int unsigned DC = 3;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, reset, start, idValid, idUsesRt, idHalt, exMemRead, branchTaken;
  logic [4:0]    idRs, idRt, exRt;
  logic          pcWrite, ifIdWrite, ifIdFlush, idExFlush, halted;
  logic [1:0]    state;
  logic [CW-1:0] stallCount, flushCount;

  int checks = 0;
  int fails  = 0;

  hazard_controller #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .idValid(idValid),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt), .idHalt(idHalt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush), .halted(halted), .state(state),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = 0;   // 0 idle, 1 run, 2 drain, 3 halted
  int m_left  = 0;   // DRAIN cycles still to be spent
  int m_stall = 0;
  int m_flush = 0;
  bit m_valid = 1'b0;
  int sat_max = (1 << CW) - 1;

  function automatic bit lu();
    return idValid && exMemRead && exRt != 0 &&
           (exRt == idRs || (idUsesRt && exRt == idRt));
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      m_state = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      case (m_state)
        0: if (start) m_state = 1;
        1: begin
          if (branchTaken) begin
            if (m_flush < sat_max) m_flush++;
          end else if (lu()) begin
            if (m_stall < sat_max) m_stall++;
          end else if (idHalt && idValid) begin
            m_state = 2;
            m_left  = DC;
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end
        default: ;
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    int e_pc, e_w, e_iff, e_ief, e_h;
    if (m_valid) begin
      e_pc = 0; e_w = 0; e_iff = 0; e_ief = 0; e_h = 0;
      if (!reset) begin
        if (m_state == 1) begin
          if (branchTaken)                 begin e_pc = 1; e_w = 1; e_iff = 1; e_ief = 1; end
          else if (lu())                   begin e_ief = 1; end
          else if (idHalt && idValid)      begin e_w = 1; e_iff = 1; end
          else                             begin e_pc = 1; e_w = 1; end
        end else if (m_state == 2) begin
          e_iff = 1; e_ief = 1;
        end else if (m_state == 3) begin
          e_h = 1;
        end
      end
      check("pcWrite",    int'(pcWrite),    e_pc);
      check("ifIdWrite",  int'(ifIdWrite),  e_w);
      check("ifIdFlush",  int'(ifIdFlush),  e_iff);
      check("idExFlush",  int'(idExFlush),  e_ief);
      check("halted",     int'(halted),     e_h);
      check("state",      int'(state),      m_state);
      check("stallCount", int'(stallCount), STATS ? m_stall : 0);
      check("flushCount", int'(flushCount), STATS ? m_flush : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drv(input bit v, input int rs, input int rt, input bit ut,
                     input bit h, input bit mr, input int ert, input bit bt);
    idValid = v; idRs = 5'(rs); idRt = 5'(rt); idUsesRt = ut;
    idHalt = h; exMemRead = mr; exRt = 5'(ert); branchTaken = bt;
  endtask

  task automatic quiet();
    drv(1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic restart();
    reset = 1'b1; start = 1'b0; quiet();
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; quiet();
    tick(); tick();
    settle();
    check("reset_state", int'(state), 0);
    check("reset_pcWrite", int'(pcWrite), 0);
    reset = 1'b0;
    tick();
    check("idle_hold", int'(state), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("start_state", int'(state), 1);
    check("run_pcWrite", int'(pcWrite), 1);
    check("run_ifIdWrite", int'(ifIdWrite), 1);

    // Load-use on rs.
    drv(1'b1, 8, 2, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    settle();
    check("lu_pcWrite", int'(pcWrite), 0);
    check("lu_ifIdWrite", int'(ifIdWrite), 0);
    check("lu_idExFlush", int'(idExFlush), 1);
    tick();
    quiet();
    settle();
    check("lu_stallCount", int'(stallCount), STATS ? 1 : 0);
    check("lu_released", int'(pcWrite), 1);

    // Same with exRt = 0: no hazard.
    drv(1'b1, 0, 2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    settle();
    check("r0_no_stall", int'(pcWrite), 1);
    tick();
    // Hazard through rt only when rt is a source.
    drv(1'b1, 3, 5, 1'b1, 1'b0, 1'b1, 5, 1'b0); tick();
    drv(1'b1, 3, 5, 1'b0, 1'b0, 1'b1, 5, 1'b0); tick();
    drv(1'b0, 5, 5, 1'b1, 1'b0, 1'b1, 5, 1'b0); tick();

    // Branch overrides load-use and halt.
    drv(1'b1, 8, 2, 1'b0, 1'b1, 1'b1, 8, 1'b1);
    settle();
    check("br_pcWrite", int'(pcWrite), 1);
    check("br_ifIdFlush", int'(ifIdFlush), 1);
    check("br_idExFlush", int'(idExFlush), 1);
    tick();
    quiet();
    settle();
    check("br_state", int'(state), 1);
    check("br_flushCount", int'(flushCount), STATS ? 1 : 0);

    // Saturation: 16 more stall cycles on a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 9, 2, 1'b0, 1'b0, 1'b1, 9, 1'b0);
      tick();
    end
    quiet();
    settle();
    check("sat_stallCount", int'(stallCount), STATS ? 15 : 0);

    // HALT behind a load-use stall, then drain with a branch that must be ignored.
    drv(1'b1, 7, 2, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    tick();
    check("halt_stalled_state", int'(state), 1);
    drv(1'b1, 7, 2, 1'b0, 1'b1, 1'b0, 7, 1'b0);
    tick();
    drv(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    n = 0;
    while (state == 2'd2 && n < 10) begin
      tick();
      n++;
    end
    check("drain_cycles", n, 3);
    quiet();
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    settle();
    check("halted_state", int'(state), 3);
    check("halted_flag", int'(halted), 1);

    // Reset in the second DRAIN cycle.
    restart();
    drv(1'b1, 8, 2, 1'b0, 1'b0, 1'b1, 8, 1'b0); tick();
    drv(1'b1, 1, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0); tick();
    quiet(); tick();
    check("mid_drain_state", int'(state), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rst_drain_state", int'(state), 0);
    check("rst_drain_halted", int'(halted), 0);
    check("rst_drain_stall", int'(stallCount), 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
